// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared size codes, FSM state type and default timeout for bus_master_rw.
package soc_bus_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam int TIMEOUT_CYCLES_DEF = 255;
    typedef enum logic [2:0] {IDLE, WR, RD, RDW, RSP} state_e;
endpackage

// File: rtl/bus_lane_encoder.sv
// bus_lane_encoder: byteenable, lane-replicated writedata and misalignment flag for one command.
module bus_lane_encoder
    import soc_bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rep_o,
    output logic        misaligned_o
);
    assign be_o = (size_i == SIZE_BYTE) ? 4'b0001 << addr_lo_i :
                  (size_i == SIZE_HALF) ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) :
                  (size_i == SIZE_WORD) ? 4'b1111 : 4'b0000;
    assign wdata_rep_o = (size_i == SIZE_BYTE) ? {4{wdata_i[7:0]}} :
                         (size_i == SIZE_HALF) ? {2{wdata_i[15:0]}} : wdata_i;
    // Reserved size is folded into the same error flag as misalignment.
    assign misaligned_o = (size_i == 2'd3) ||
                          (size_i == SIZE_HALF && addr_lo_i[0]) ||
                          (size_i == SIZE_WORD && addr_lo_i != 2'd0);
endmodule

// File: rtl/bus_master_rw.sv
// bus_master_rw: single-outstanding byte/half/word load-store initiator on a 32-bit Avalon-MM style bus.
// Define BUS_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES cycles.
module bus_master_rw
    import soc_bus_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_size,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d, write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        size_q, size_d, lane_q, lane_d;
    logic [3:0]        enc_be;
    logic [31:0]       enc_wdata, rd_shift, rd_data;
    logic              enc_err, timeout;

    bus_lane_encoder u_enc (
        .size_i       (cmd_size),
        .addr_lo_i    (cmd_addr[1:0]),
        .wdata_i      (cmd_wdata),
        .be_o         (enc_be),
        .wdata_rep_o  (enc_wdata),
        .misaligned_o (enc_err)
    );

    assign rd_shift = avm_readdata >> {lane_q, 3'b000};
    assign rd_data  = (size_q == SIZE_BYTE) ? {24'd0, rd_shift[7:0]} :
                      (size_q == SIZE_HALF) ? {16'd0, rd_shift[15:0]} : rd_shift;

`ifdef BUS_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        busy;
    assign busy = (state_q == WR) || (state_q == RD) || (state_q == RDW);
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= busy ? cnt_q + 16'd1 : 16'd0;
    assign timeout = busy && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
    assign timeout = 1'b0;
`endif

    // Bus and response outputs default to 0; only the holding states re-assert them.
    always_comb begin
        state_d     = state_q;
        addr_d      = '0;
        read_d      = 1'b0;
        write_d     = 1'b0;
        wdata_d     = '0;
        be_d        = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        size_d      = size_q;
        lane_d      = lane_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                size_d = cmd_size;
                lane_d = cmd_addr[1:0];
                if (enc_err) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = cmd_write ? WR : RD;
                    addr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
                    be_d    = enc_be;
                    wdata_d = cmd_write ? enc_wdata : 32'd0;
                    write_d = cmd_write;
                    read_d  = !cmd_write;
                end
            end
            WR: if (!avm_waitrequest) begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
            end else if (timeout) begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end else begin
                addr_d  = addr_q;
                be_d    = be_q;
                wdata_d = wdata_q;
                write_d = 1'b1;
            end
            RD: if (!avm_waitrequest && avm_readdatavalid) begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rd_data;
            end else if (timeout) begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end else if (!avm_waitrequest) begin
                state_d = RDW;
            end else begin
                addr_d = addr_q;
                be_d   = be_q;
                read_d = 1'b1;
            end
            RDW: if (avm_readdatavalid) begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rd_data;
            end else if (timeout) begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            size_q      <= '0;
            lane_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;
endmodule

// File: tb/tb_bus_master_rw.sv
// tb_bus_master_rw: table-driven directed bench for bus_master_rw plus back-to-back, reset and stall sequences.
module tb_bus_master_rw;
    logic        clock = 1'b0, resetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [1:0]  cmd_size = '0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = '0;
    int checks = 0, failures = 0;

    always #5 clock = ~clock;

    bus_master_rw #(.ADDR_W(16), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          rdv_dly;
        logic [31:0] rdata;
        logic        err;
        logic [15:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic w, input logic [1:0] s, input logic [15:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_size  = s;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int acc, rsp;
        logic req;
        acc = v.waits + 1;
        rsp = v.err ? 1 : (v.write ? acc + 1 : acc + 1 + v.rdv_dly);
        @(negedge clock);
        chk({tag, " ready0"}, 32'(cmd_ready), 32'd1);
        drive_cmd(v.write, v.size, v.addr, v.wdata);
        avm_waitrequest = 1'b1;
        for (int c = 1; c <= rsp + 1; c++) begin
            @(negedge clock);
            if (c == 1) cmd_valid = 1'b0;
            req = !v.err && c <= acc;
            chk($sformatf("%s c%0d rdwr", tag, c), {30'd0, avm_read, avm_write},
                req ? {30'd0, !v.write, v.write} : 32'd0);
            chk($sformatf("%s c%0d addr", tag, c), 32'(avm_address), req ? 32'(v.exp_addr) : 32'd0);
            chk($sformatf("%s c%0d be", tag, c), 32'(avm_byteenable), req ? 32'(v.exp_be) : 32'd0);
            chk($sformatf("%s c%0d wd", tag, c), avm_writedata, (req && v.write) ? v.exp_wd : 32'd0);
            chk($sformatf("%s c%0d rsp_valid", tag, c), 32'(rsp_valid), 32'(c == rsp));
            if (c == rsp) begin
                chk({tag, " err"}, 32'(rsp_err), 32'(v.err));
                chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
            end
            chk($sformatf("%s c%0d ready", tag, c), 32'(cmd_ready), 32'(c == rsp + 1));
            avm_waitrequest   = (c < acc);
            avm_readdatavalid = !v.err && !v.write && (c == acc + v.rdv_dly);
            avm_readdata      = avm_readdatavalid ? v.rdata : 32'hDEAD_BEEF;
        end
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
    endtask

    initial begin
        int low_cnt, rsp_cnt;
        vecs[0]  = '{1'b1, 2'd0, 16'h0006, 32'h0000_00AB, 0, 0, 32'h0, 1'b0, 16'h0004, 4'b0100, 32'hABAB_ABAB, 32'h0};
        vecs[1]  = '{1'b0, 2'd1, 16'h0012, 32'h0, 2, 1, 32'h1234_5678, 1'b0, 16'h0010, 4'b1100, 32'h0, 32'h0000_1234};
        vecs[2]  = '{1'b0, 2'd2, 16'h0003, 32'h0, 0, 0, 32'h1111_1111, 1'b1, 16'h0, 4'b0, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 2'd3, 16'h0000, 32'h0, 0, 0, 32'h2222_2222, 1'b1, 16'h0, 4'b0, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, 2'd1, 16'h0021, 32'h0000_BEEF, 0, 0, 32'h0, 1'b1, 16'h0, 4'b0, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 2'd2, 16'h0100, 32'hDEAD_BEEF, 1, 0, 32'h0, 1'b0, 16'h0100, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[6]  = '{1'b1, 2'd1, 16'h0042, 32'h1234_CDEF, 0, 0, 32'h0, 1'b0, 16'h0040, 4'b1100, 32'hCDEF_CDEF, 32'h0};
        vecs[7]  = '{1'b0, 2'd0, 16'h0007, 32'h0, 0, 0, 32'hA1B2_C3D4, 1'b0, 16'h0004, 4'b1000, 32'h0, 32'h0000_00A1};
        vecs[8]  = '{1'b0, 2'd0, 16'h0005, 32'h0, 0, 2, 32'hA1B2_C3D4, 1'b0, 16'h0004, 4'b0010, 32'h0, 32'h0000_00C3};
        vecs[9]  = '{1'b0, 2'd2, 16'h0008, 32'h0, 1, 0, 32'h89AB_CDEF, 1'b0, 16'h0008, 4'b1111, 32'h0, 32'h89AB_CDEF};
        vecs[10] = '{1'b0, 2'd1, 16'h0000, 32'h0, 0, 3, 32'hFFFF_8001, 1'b0, 16'h0000, 4'b0011, 32'h0, 32'h0000_8001};
        vecs[11] = '{1'b1, 2'd0, 16'h0003, 32'h1234_5678, 0, 0, 32'h0, 1'b0, 16'h0000, 4'b1000, 32'h7878_7878, 32'h0};
        vecs[12] = '{1'b1, 2'd2, 16'h0002, 32'h0, 0, 0, 32'h0, 1'b1, 16'h0, 4'b0, 32'h0, 32'h0};

        repeat (2) @(negedge clock);
        chk("reset ready", 32'(cmd_ready), 32'd1);
        chk("reset rsp", {29'd0, rsp_valid, rsp_err, |rsp_rdata}, 32'd0);
        chk("reset bus", {avm_read, avm_write, |avm_address, |avm_writedata, |avm_byteenable}, 32'd0);
        resetn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back with cmd_valid held high.
        @(negedge clock);
        drive_cmd(1'b1, 2'd2, 16'h0030, 32'h0102_0304);
        chk("b2b c0 ready", 32'(cmd_ready), 32'd1);
        @(negedge clock);
        chk("b2b c1 write", {avm_write, cmd_ready}, 32'b10);
        @(negedge clock);
        chk("b2b c2 rsp", {rsp_valid, avm_read, avm_write, cmd_ready}, 32'b1000);
        @(negedge clock);
        chk("b2b c3 second hs", {rsp_valid, avm_read, avm_write, cmd_ready}, 32'b0001);
        @(negedge clock);
        chk("b2b c4 write", {avm_write, cmd_ready, rsp_valid}, 32'b100);
        cmd_valid = 1'b0;
        @(negedge clock);
        chk("b2b c5 rsp", {rsp_valid, rsp_err, avm_write}, 32'b100);

        // Async reset mid-read, then a stray readdatavalid.
        @(negedge clock);
        drive_cmd(1'b0, 2'd2, 16'h0010, 32'h0);
        avm_waitrequest = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("rst pre read", {avm_read, |avm_address}, 32'b11);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("rst bus zero", {avm_read, avm_write, |avm_address, |avm_byteenable, rsp_valid, rsp_err}, 32'd0);
        chk("rst ready", 32'(cmd_ready), 32'd1);
        @(negedge clock);
        resetn = 1'b1;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hCAFE_F00D;
        @(negedge clock);
        avm_readdatavalid = 1'b0;
        rsp_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            rsp_cnt += int'(rsp_valid) + int'(avm_read) + int'(!cmd_ready);
            @(negedge clock);
        end
        chk("rst stray rdv ignored", 32'(rsp_cnt), 32'd0);
        run_vec(vecs[1], "post_rst");

        // Waitrequest stuck high on a store.
        @(negedge clock);
        drive_cmd(1'b1, 2'd2, 16'h0020, 32'h0000_0055);
        avm_waitrequest = 1'b1;
        low_cnt = 0;
        rsp_cnt = 0;
`ifdef BUS_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 1) cmd_valid = 1'b0;
            low_cnt += int'(!avm_write);
            rsp_cnt += int'(rsp_valid);
        end
        chk("to held 8", 32'(low_cnt), 32'd0);
        chk("to no early rsp", 32'(rsp_cnt), 32'd0);
        @(negedge clock);
        chk("to abort", {avm_write, rsp_valid, rsp_err}, 32'b011);
        chk("to rdata", rsp_rdata, 32'd0);
        avm_waitrequest = 1'b0;
`else
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (c == 1) cmd_valid = 1'b0;
            low_cnt += int'(!avm_write);
            rsp_cnt += int'(rsp_valid);
        end
        chk("stall held 100", 32'(low_cnt), 32'd0);
        chk("stall no rsp", 32'(rsp_cnt), 32'd0);
        avm_waitrequest = 1'b0;
        @(negedge clock);
        chk("stall release rsp", {avm_write, rsp_valid, rsp_err}, 32'b010);
`endif
        @(negedge clock);
        chk("final ready", 32'(cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
